phase_fifo_align_ctrl: RTL and testbench

- wr_clk-domain controller that sequences the reset of a 2-clock phase-compensation FIFO and monitors its write/read pointer distance.
- Holds the FIFO in reset until enabled, releases it, and waits for the pointers to settle before declaring lock.
- While locked, it re-aligns the FIFO (re-reset) when the pointer distance leaves a legal window for too long.
- Sits beside the FIFO. It drives the FIFO's sreset_n, and receives the read pointer as Gray code from the rd_clk domain.

---
 rtl/phase_fifo_align_ctrl.sv | 173 +++++++++++++++++
 tb/tb_phase_fifo_align_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_fifo_align_ctrl.sv
// phase_fifo_align_ctrl
//   wr_clk-domain reset sequencer and pointer-distance monitor for a 2-clock
//   phase-compensation FIFO. Holds the FIFO in reset until enabled, releases
//   it, waits for the pointers to settle, declares lock, and re-aligns the
//   FIFO when the write/read distance stays outside a legal window.
// Ports:
//   wr_clk        in   FIFO write clock
//   sreset_n      in   synchronous active-low reset
//   enable        in   1 = run the FIFO, 0 = hold it in reset
//   rd_ptr_gray   in   FIFO read pointer, Gray coded, rd_clk domain
//   fifo_sreset_n out  registered active-low reset to the FIFO
//   locked        out  registered; FIFO aligned and in window
//   align_err     out  one-cycle pulse when a re-align is triggered
//   realign_cnt   out  saturating count of re-aligns since sreset_n
//   occupancy     out  registered write/read pointer distance (debug)
module phase_fifo_align_ctrl #(
   parameter int unsigned PTR_WIDTH     = 3,
   parameter int unsigned MIN_OCC       = 1,
   parameter int unsigned MAX_OCC       = 6,
   parameter int unsigned ERR_CYCLES    = 4,
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                 wr_clk,
   input  logic                 sreset_n,
   input  logic                 enable,
   input  logic [PTR_WIDTH-1:0] rd_ptr_gray,
   output logic                 fifo_sreset_n,
   output logic                 locked,
   output logic                 align_err,
   output logic [CNT_W-1:0]     realign_cnt,
   output logic [PTR_WIDTH-1:0] occupancy
);

   localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CNT_DW  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned ERR_W   = $clog2(ERR_CYCLES + 1);

   localparam logic [CNT_DW-1:0]    RST_LOAD    = CNT_DW'(RST_CYCLES - 1);
   localparam logic [CNT_DW-1:0]    SETTLE_LOAD = CNT_DW'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0]     ERR_LAST    = ERR_W'(ERR_CYCLES - 1);
   localparam logic [PTR_WIDTH-1:0] MIN_W       = PTR_WIDTH'(MIN_OCC);
   localparam logic [PTR_WIDTH-1:0] MAX_W       = PTR_WIDTH'(MAX_OCC);

   typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_SETTLE, ST_LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [CNT_DW-1:0]      cnt_q, cnt_d;
   logic [ERR_W-1:0]       err_q, err_d;
   logic [PTR_WIDTH-1:0]   sync1_q, sync2_q;
   logic [PTR_WIDTH-1:0]   wp_q, wp_d;
   logic [PTR_WIDTH-1:0]   occ_q, occ_d;
   logic [PTR_WIDTH-1:0]   rd_ptr_bin;
   logic                   fifo_rst_n_q, fifo_rst_n_d;
   logic                   locked_q, locked_d;
   logic                   align_err_q, align_err_d;
   logic [CNT_W-1:0]       realign_q, realign_d;
   logic                   in_win;
   logic                   err_trig;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rd_ptr_bin = '0;
      for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
         rd_ptr_bin[i] = ^(sync2_q >> i);
      end
   end

   always_comb begin
      in_win   = (occ_q >= MIN_W) && (occ_q <= MAX_W);
      // Fires on the cycle the error run would reach ERR_CYCLES.
      err_trig = (state_q == ST_LOCKED) && !in_win && (err_q == ERR_LAST);
   end

   // State register (plus datapath flops)
   always_ff @(posedge wr_clk) begin
      if (!sreset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         err_q        <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         wp_q         <= '0;
         occ_q        <= '0;
         fifo_rst_n_q <= 1'b0;
         locked_q     <= 1'b0;
         align_err_q  <= 1'b0;
         realign_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         sync1_q      <= rd_ptr_gray;
         sync2_q      <= sync1_q;
         wp_q         <= wp_d;
         occ_q        <= occ_d;
         fifo_rst_n_q <= fifo_rst_n_d;
         locked_q     <= locked_d;
         align_err_q  <= align_err_d;
         realign_q    <= realign_d;
      end
   end

   // Next-state logic; enable=0 overrides the error trigger and counter expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_RESET;
               cnt_d   = RST_LOAD;
            end
            ST_RESET: begin
               if (cnt_q == '0) begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_DW'(1);
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  state_d = ST_LOCKED;
               end else begin
                  cnt_d = cnt_q - CNT_DW'(1);
               end
            end
            ST_LOCKED: begin
               if (err_trig) begin
                  state_d = ST_RESET;
                  cnt_d   = RST_LOAD;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      // Outputs are registered from the upcoming state so the FIFO is released
      // on the cycle after RESET expires and locked drops on the trigger cycle.
      fifo_rst_n_d = (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
      locked_d     = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
      align_err_d  = enable && err_trig;

      realign_d = realign_q;
      if (align_err_d && (realign_q != '1)) begin
         realign_d = realign_q + CNT_W'(1);
      end

      err_d = '0;
      if ((state_q == ST_LOCKED) && enable && !in_win && !err_trig) begin
         err_d = err_q + ERR_W'(1);
      end

      // Mirrors the FIFO's free-running write pointer, held at zero in reset.
      wp_d  = fifo_rst_n_q ? (wp_q + PTR_WIDTH'(1)) : '0;
      occ_d = wp_q - rd_ptr_bin;
   end

   assign fifo_sreset_n = fifo_rst_n_q;
   assign locked        = locked_q;
   assign align_err     = align_err_q;
   assign realign_cnt   = realign_q;
   assign occupancy     = occ_q;

endmodule

// File: tb/tb_phase_fifo_align_ctrl.sv
// tb_phase_fifo_align_ctrl
//   Scoreboard bench for phase_fifo_align_ctrl. A timeline model (cycles since
//   the current reset sequence started) predicts every output after each
//   clock edge; a monitor pops and compares. A second instance with CNT_W=2
//   exercises realign_cnt saturation on the same stimulus.
module tb_phase_fifo_align_ctrl;

   localparam int PW     = 3;
   localparam int N      = 8;
   localparam int MINO   = 1;
   localparam int MAXO   = 6;
   localparam int ERRC   = 4;
   localparam int RSTC   = 4;
   localparam int SETC   = 8;

   logic          wr_clk = 1'b0;
   logic          sreset_n;
   logic          enable;
   logic [PW-1:0] rd_ptr_gray;

   logic          fifo_sreset_n, locked, align_err;
   logic [7:0]    realign_cnt;
   logic [PW-1:0] occupancy;

   logic          fifo_sreset_n2, locked2, align_err2;
   logic [1:0]    realign_cnt2;
   logic [PW-1:0] occupancy2;

   always #5 wr_clk = ~wr_clk;

   phase_fifo_align_ctrl dut (
      .wr_clk(wr_clk), .sreset_n(sreset_n), .enable(enable),
      .rd_ptr_gray(rd_ptr_gray), .fifo_sreset_n(fifo_sreset_n),
      .locked(locked), .align_err(align_err), .realign_cnt(realign_cnt),
      .occupancy(occupancy)
   );

   phase_fifo_align_ctrl #(.CNT_W(2)) dut2 (
      .wr_clk(wr_clk), .sreset_n(sreset_n), .enable(enable),
      .rd_ptr_gray(rd_ptr_gray), .fifo_sreset_n(fifo_sreset_n2),
      .locked(locked2), .align_err(align_err2), .realign_cnt(realign_cnt2),
      .occupancy(occupancy2)
   );

   typedef struct {
      int fifo;
      int lock;
      int aerr;
      int rcnt;
      int occ;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int m_j    = -1;  // edges since current reset sequence started, -1 = idle
   int m_err  = 0;   // consecutive out-of-window cycles while locked
   int m_rcnt = 0;
   int m_wp   = 0;
   int m_occ  = 0;
   int m_fifo = 0;
   int m_g1   = 0;
   int m_g2   = 0;

   function automatic int gray_to_bin(int g);
      for (int b = 0; b < N; b++) begin
         if ((b ^ (b >> 1)) == g) return b;
      end
      return 0;
   endfunction

   function automatic bit in_window(int o);
      return (o >= MINO) && (o <= MAXO);
   endfunction

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_edge(bit rn, bit en, int g);
      exp_t e;
      int   occ_before  = m_occ;
      int   fifo_before = m_fifo;
      int   wp_before   = m_wp;
      int   aerr        = 0;
      if (!rn) begin
         m_j = -1; m_err = 0; m_rcnt = 0; m_wp = 0; m_occ = 0; m_fifo = 0;
         m_g1 = 0; m_g2 = 0;
      end else begin
         m_occ = ((wp_before - gray_to_bin(m_g2)) % N + N) % N;
         m_g2  = m_g1;
         m_g1  = g;
         m_wp  = (fifo_before != 0) ? (wp_before + 1) % N : 0;
         if (!en) begin
            m_j = -1; m_err = 0;
         end else if (m_j < 0) begin
            m_j = 0; m_err = 0;
         end else if (m_j >= RSTC + SETC) begin
            if (in_window(occ_before)) m_err = 0;
            else                       m_err++;
            if (m_err == ERRC) begin
               aerr = 1;
               if (m_rcnt < 255) m_rcnt++;
               m_j = 0; m_err = 0;
            end else begin
               m_j++;
            end
         end else begin
            m_j++; m_err = 0;
         end
         m_fifo = (m_j >= RSTC) ? 1 : 0;
      end
      e.fifo = m_fifo;
      e.lock = (m_j >= RSTC + SETC + 1) ? 1 : 0;
      e.aerr = aerr;
      e.rcnt = m_rcnt;
      e.occ  = m_occ;
      sb_q.push_back(e);
   endtask

   task automatic step_g(bit rn, bit en, int g);
      sreset_n    = rn;
      enable      = en;
      rd_ptr_gray = PW'(g);
      model_edge(rn, en, g);
      @(negedge wr_clk);
   endtask

   // Drives the Gray code that yields occupancy=tgt three edges later while
   // the write pointer is free-running.
   task automatic step(bit rn, bit en, int tgt);
      int b;
      b = ((m_wp + 2 - tgt) % N + N) % N;
      step_g(rn, en, b ^ (b >> 1));
   endtask

   exp_t mon_e;
   initial begin
      forever begin
         @(posedge wr_clk);
         #1;
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("fifo_sreset_n", int'(fifo_sreset_n), mon_e.fifo);
            chk("locked",        int'(locked),        mon_e.lock);
            chk("align_err",     int'(align_err),     mon_e.aerr);
            chk("realign_cnt",   int'(realign_cnt),   mon_e.rcnt);
            chk("occupancy",     int'(occupancy),     mon_e.occ);
            chk("realign_cnt_w2", int'(realign_cnt2), (mon_e.rcnt > 3) ? 3 : mon_e.rcnt);
         end
      end
   end

   initial begin
      int n;
      int tgt;
      int r;
      sreset_n    = 1'b0;
      enable      = 1'b0;
      rd_ptr_gray = '0;

      repeat (3) step_g(0, 0, 0);

      // Lock with occupancy 3
      repeat (30) step(1, 1, 3);

      // Occupancy 0 long enough to trigger, then relock
      repeat (8) step(1, 1, 0);
      repeat (30) step(1, 1, 3);

      // Short out-of-window runs never trigger
      repeat (5) begin
         repeat (3) step(1, 1, 7);
         step(1, 1, 3);
      end
      repeat (4) step(1, 1, 3);

      // Drop enable in SETTLE, then in LOCKED
      step(1, 0, 3);
      repeat (8) step(1, 1, 3);
      repeat (2) step(1, 0, 3);
      repeat (20) step(1, 1, 3);
      repeat (2) step(1, 0, 3);
      repeat (20) step(1, 1, 3);

      // enable=0 on the exact trigger cycle suppresses pulse and count
      n = 0;
      while (!(m_j >= RSTC + SETC && m_err == ERRC - 1 && !in_window(m_occ)) && n < 100) begin
         step(1, 1, 0);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL trigger_wait: got timeout expected trigger-ready state");
      end
      step(1, 0, 0);
      repeat (20) step(1, 1, 3);

      // Repeated re-aligns saturate the 2-bit counter
      repeat (6 * 17 + 5) step(1, 1, 0);
      n = 0;
      while (m_j != 1 && n < 40) begin
         step(1, 1, 0);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL reset_wait: got timeout expected RESET phase");
      end
      step(1, 1, 0);       // mid-RESET
      step(0, 1, 0);       // sreset_n asserted
      repeat (20) step(1, 1, 3);

      // Gray sweep with the FIFO held in reset (write pointer fixed at 0)
      repeat (3) step(1, 0, 3);
      for (int c = 0; c < N; c++) begin
         repeat (4) step_g(1, 0, c);
      end

      // Randomised run
      tgt = 3;
      repeat (500) begin
         r = int'($urandom_range(0, 199));
         if ($urandom_range(0, 5) == 0) begin
            tgt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7))
                                              : int'($urandom_range(MINO, MAXO));
         end
         if (r == 0)            step(0, 1, tgt);
         else if (r < 4)        step(1, 0, tgt);
         else if (r < 10)       step_g(1, 1, int'($urandom_range(0, 7)));
         else                   step(1, 1, tgt);
      end

      repeat (2) @(negedge wr_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
